// File: rtl/pair_match_ctl_pkg.sv
// Shared game package: card-state encodings and the pair-match FSM states.
package pair_match_ctl_pkg;

   // Per-card state as written to the regfile controller
   typedef enum logic [1:0] {
      CARD_HIDDEN  = 2'b00,
      CARD_FACE_UP = 2'b01,
      CARD_MATCHED = 2'b10
   } card_state_t;

   // Pair-match controller states
   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_FIRST,
      S_WAIT_SECOND,
      S_COMPARE,
      S_SHOW,
      S_HIDE_A,
      S_HIDE_B,
      S_MATCH_A,
      S_MATCH_B,
      S_DONE
   } state_t;

endpackage

// File: rtl/pair_match_ctl_hold_timer.sv
// Hold timer: load arms it for CYCLES counted cycles; done is high on the
// last of them, so a state held while counting lasts exactly CYCLES cycles.
module hold_timer #(
   parameter  int CYCLES = 2,
   localparam int CNT_W  = $clog2(CYCLES + 1)
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_count,
   output logic o_done
);

   logic [CNT_W-1:0] r_cnt;

   // Down-counter: load to CYCLES-1, decrement while counting, stick at 0
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= CNT_W'(CYCLES - 1);
      else if (i_count && (r_cnt != '0))
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/pair_match_ctl.sv
// Memory-game pair-match controller: takes two card clicks, compares their
// colours, and issues card-state writes (face-up, matched, or hidden again
// after a hold period). All writes are registered, one cycle after the cause.
module pair_match_ctl
   import pair_match_ctl_pkg::*;
#(
   parameter  int NUM_CARDS   = 12,
   parameter  int COLOR_W     = 12,
   parameter  int SHOW_CYCLES = 65000000,
   parameter  int MOVES_W     = 10,
   localparam int ADDR_W      = $clog2(NUM_CARDS)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_card_pressed,
   input  logic [ADDR_W-1:0]  i_card_addr,
   input  logic [COLOR_W-1:0] i_card_color,
   output logic               o_accept_click,
   output logic               o_write_en,
   output logic [ADDR_W-1:0]  o_write_addr,
   output logic [1:0]         o_write_state,
   output logic [MOVES_W-1:0] o_moves,
   output logic [ADDR_W-1:0]  o_pairs_found,
   output logic               o_game_over,
   output logic               o_playing
);

   state_t                       r_state, w_next;
   card_state_t [NUM_CARDS-1:0]  r_card;
   logic [ADDR_W-1:0]            r_a_addr, r_b_addr;
   logic [COLOR_W-1:0]           r_a_color, r_b_color;
   logic [MOVES_W-1:0]           r_moves;
   logic [ADDR_W-1:0]            r_pairs;
   logic                         r_game_over;
   logic                         r_we;
   logic [ADDR_W-1:0]            r_waddr;
   card_state_t                  r_wstate;

   logic                         w_we;
   logic [ADDR_W-1:0]            w_waddr;
   card_state_t                  w_wstate;
   logic                         w_latch_a, w_latch_b, w_clear;
   logic                         w_inc_moves, w_inc_pairs, w_game_over;
   logic                         w_tmr_load, w_tmr_count, w_tmr_done;
   logic                         w_accept, w_addr_ok, w_click_ok;
   logic [ADDR_W-1:0]            w_idx;

   assign w_accept   = (r_state == S_WAIT_FIRST) || (r_state == S_WAIT_SECOND);
   assign w_addr_ok  = ({1'b0, i_card_addr} < (ADDR_W+1)'(NUM_CARDS));
   assign w_idx      = w_addr_ok ? i_card_addr : '0;
   // Only a hidden, in-range card clicked while accepting counts; this also
   // rules out re-clicking card A as card B since A is already face-up.
   assign w_click_ok = i_card_pressed && w_accept && w_addr_ok &&
                       (r_card[w_idx] == CARD_HIDDEN);

   hold_timer #(.CYCLES(SHOW_CYCLES)) u_show_timer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_tmr_load),
      .i_count (w_tmr_count),
      .o_done  (w_tmr_done)
   );

   // Next-state and next-write decode
   always_comb begin
      w_next      = r_state;
      w_we        = 1'b0;
      w_waddr     = '0;
      w_wstate    = CARD_HIDDEN;
      w_latch_a   = 1'b0;
      w_latch_b   = 1'b0;
      w_clear     = 1'b0;
      w_inc_moves = 1'b0;
      w_inc_pairs = 1'b0;
      w_game_over = 1'b0;
      w_tmr_load  = 1'b0;
      w_tmr_count = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_clear = 1'b1;
               w_next  = S_WAIT_FIRST;
            end
         end
         S_WAIT_FIRST: begin
            if (w_click_ok) begin
               w_latch_a = 1'b1;
               w_we      = 1'b1;
               w_waddr   = i_card_addr;
               w_wstate  = CARD_FACE_UP;
               w_next    = S_WAIT_SECOND;
            end
         end
         S_WAIT_SECOND: begin
            if (w_click_ok) begin
               w_latch_b = 1'b1;
               w_we      = 1'b1;
               w_waddr   = i_card_addr;
               w_wstate  = CARD_FACE_UP;
               w_next    = S_COMPARE;
            end
         end
         S_COMPARE: begin
            w_inc_moves = 1'b1;
            if (r_a_color == r_b_color) begin
               // (A, matched) lands during MATCH_A
               w_we     = 1'b1;
               w_waddr  = r_a_addr;
               w_wstate = CARD_MATCHED;
               w_next   = S_MATCH_A;
            end else begin
               w_tmr_load = 1'b1;
               w_next     = S_SHOW;
            end
         end
         S_MATCH_A: begin
            w_we     = 1'b1;
            w_waddr  = r_b_addr;
            w_wstate = CARD_MATCHED;
            w_next   = S_MATCH_B;
         end
         S_MATCH_B: begin
            w_inc_pairs = 1'b1;
            if (r_pairs == ADDR_W'(NUM_CARDS/2 - 1)) begin
               w_game_over = 1'b1;
               w_next      = S_DONE;
            end else begin
               w_next = S_WAIT_FIRST;
            end
         end
         S_SHOW: begin
            w_tmr_count = 1'b1;
            if (w_tmr_done) begin
               w_we     = 1'b1;
               w_waddr  = r_a_addr;
               w_wstate = CARD_HIDDEN;
               w_next   = S_HIDE_A;
            end
         end
         S_HIDE_A: begin
            w_we     = 1'b1;
            w_waddr  = r_b_addr;
            w_wstate = CARD_HIDDEN;
            w_next   = S_HIDE_B;
         end
         S_HIDE_B: w_next = S_WAIT_FIRST;
         default:  w_next = S_IDLE;
      endcase
   end

   // State, latches, counters and registered write strobe
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_a_addr    <= '0;
         r_b_addr    <= '0;
         r_a_color   <= '0;
         r_b_color   <= '0;
         r_moves     <= '0;
         r_pairs     <= '0;
         r_game_over <= 1'b0;
         r_we        <= 1'b0;
         r_waddr     <= '0;
         r_wstate    <= CARD_HIDDEN;
      end else begin
         r_state     <= w_next;
         r_game_over <= w_game_over;
         r_we        <= w_we;
         r_waddr     <= w_waddr;
         r_wstate    <= w_wstate;
         if (w_latch_a) begin
            r_a_addr  <= i_card_addr;
            r_a_color <= i_card_color;
         end
         if (w_latch_b) begin
            r_b_addr  <= i_card_addr;
            r_b_color <= i_card_color;
         end
         if (w_clear) begin
            r_moves <= '0;
            r_pairs <= '0;
         end else begin
            if (w_inc_moves && (r_moves != '1))
               r_moves <= r_moves + 1'b1;
            if (w_inc_pairs)
               r_pairs <= r_pairs + 1'b1;
         end
      end
   end

   // Card-state mirror, updated on the same edge the write is registered
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_CARDS; i++) r_card[i] <= CARD_HIDDEN;
      end else if (w_clear) begin
         for (int i = 0; i < NUM_CARDS; i++) r_card[i] <= CARD_HIDDEN;
      end else if (w_we) begin
         r_card[w_waddr] <= w_wstate;
      end
   end

   assign o_accept_click = w_accept;
   assign o_write_en     = r_we;
   assign o_write_addr   = r_waddr;
   assign o_write_state  = r_wstate;
   assign o_moves        = r_moves;
   assign o_pairs_found  = r_pairs;
   assign o_game_over    = r_game_over;
   assign o_playing      = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: doc/pair_match_ctl.md
PAIR_MATCH_CTL -- requirements
Module: pair_match_ctl

Interface
REQ-001 Parameter NUM_CARDS, default 12, SHALL be the card count; even, 4..32.
REQ-002 Parameter COLOR_W, default 12, SHALL be the card colour width.
REQ-003 Parameter SHOW_CYCLES, default 65000000, SHALL be the hold time, in clk cycles, of a mismatched pair (>=2).
REQ-004 Parameter MOVES_W, default 10, SHALL be the move-counter width; local ADDR_W = clog2(NUM_CARDS).
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 start  in  1  one-cycle pulse; begins a game.
REQ-008 card_pressed  in  1  one-cycle pulse; a card was clicked.
REQ-009 card_addr  in  ADDR_W  clicked card index; valid with card_pressed.
REQ-010 card_color  in  COLOR_W  clicked card colour; valid with card_pressed.
REQ-011 accept_click  out  1  high while clicks are accepted (WAIT_FIRST, WAIT_SECOND).
REQ-012 write_en  out  1  one-cycle card-state write strobe to the regfile controller.
REQ-013 write_addr  out  ADDR_W  card index for write_en.
REQ-014 write_state  out  2  00 hidden, 01 face-up, 10 matched.
REQ-015 moves  out  MOVES_W  completed pair attempts.
REQ-016 pairs_found  out  ADDR_W  matched pair count.
REQ-017 game_over  out  1  one-cycle pulse when the last pair matches.
REQ-018 playing  out  1  high from start acceptance until DONE.

Function
REQ-019 States SHALL be IDLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW, HIDE_A, HIDE_B, MATCH_A, MATCH_B, DONE.
REQ-020 Internal 2-bit state per card SHALL mirror every write issued; all hidden on start.
REQ-021 IDLE/DONE + start -> clear moves, pairs_found, card states; -> WAIT_FIRST next cycle.
REQ-022 card_pressed SHALL be ignored unless accept_click is high in the same cycle.
REQ-023 Click on a card not hidden, or card_addr >= NUM_CARDS, SHALL be ignored (no write, no state change).
REQ-024 Valid click in WAIT_FIRST: latch addr/colour as A, issue write (A, 01) next cycle, -> WAIT_SECOND.
REQ-025 Valid click in WAIT_SECOND (B != A by REQ-023): latch B, issue write (B, 01) next cycle, -> COMPARE.
REQ-026 COMPARE (one cycle): moves += 1, saturating at all-ones; colours equal -> MATCH_A else SHOW.
REQ-027 MATCH_A writes (A, 10); MATCH_B writes (B, 10), pairs_found += 1; -> DONE with game_over pulse if pairs_found reaches NUM_CARDS/2, else WAIT_FIRST.
REQ-028 SHOW SHALL count exactly SHOW_CYCLES cycles with accept_click low, then HIDE_A writes (A, 00), HIDE_B writes (B, 00), -> WAIT_FIRST.
REQ-029 At most one write per cycle; write_addr/write_state SHALL be zero when write_en is low.
REQ-030 start outside IDLE/DONE SHALL be ignored.
REQ-031 Click-to-write latency SHALL be exactly 1 cycle; DONE holds until next start.

Reset
REQ-032 On rst: state IDLE, all outputs 0, card states hidden, SHOW counter 0, latches 0.
REQ-033 rst mid-game SHALL abort without issuing pending writes; regfile re-init belongs to compute_colors.

Structure
REQ-034 Card-state encodings (HIDDEN, FACE_UP, MATCHED) and the FSM state enum SHALL live in the shared game package.
REQ-035 SHOW timer SHALL be a sub-module hold_timer (load, count, done), reusable by stopwatch-style blocks.

Verification
REQ-036 rst, start, click 3 then 3 again -> one write (3,01) only, still WAIT_SECOND, moves 0.
REQ-037 Click 2 (colour 0x0AA), click 7 (0x0AA) -> writes (2,01),(7,01),(2,10),(7,10); moves 1, pairs_found 1.
REQ-038 SHOW_CYCLES=5; click 0 (0xF00), click 1 (0x00F) -> accept_click low 5 cycles, then (0,00),(1,00); moves 1.
REQ-039 NUM_CARDS=4; match both pairs -> game_over single pulse after second MATCH_B, playing low, start restarts with moves 0.
REQ-040 Click during SHOW and click with card_addr=12 (NUM_CARDS=12) -> no write, no state change.
REQ-041 rst asserted in SHOW -> outputs 0 same cycle, no HIDE writes afterwards.
